run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor.sv | 109 ++++++++++
 tb/tb_run_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// run_monitor: launches a CPU run, detects halt/invalid-PC/stall/timeout, then dumps all 32 registers.
// Define RUN_MONITOR_STALL_EN to compile in stall detection (cause 4).
module run_monitor #(
    parameter logic [31:0] HALT_PC     = 32'h00000100,
    parameter int          MAX_CYCLES  = 1000,
    parameter int          STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    input  logic [31:0] reg_data,
    output logic        cpu_rstn,
    output logic        cpu_hold,
    output logic [4:0]  reg_sel,
    output logic        running,
    output logic        done,
    output logic [2:0]  cause,
    output logic [31:0] cycle_count,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data
);
    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
    state_t state, next;
    logic [4:0] k;
    logic [2:0] term;
    logic launch, stall_hit;

    if (MAX_CYCLES < 2 || STALL_LIMIT < 2) begin : g_param_range_violated
    end

    assign launch = (state == IDLE || state == DONE) && start;

`ifdef RUN_MONITOR_STALL_EN
    logic [31:0] prev_pc, stall_cnt;
    logic same;
    // The first RUN cycle has no valid predecessor PC, so it never counts as a repeat.
    assign same      = cycle_count != '0 && pc_valid && pc_in == prev_pc;
    assign stall_hit = same && stall_cnt == 32'(STALL_LIMIT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc   <= '0;
            stall_cnt <= '0;
        end else if (launch) begin
            stall_cnt <= '0;
        end else if (state == RUN) begin
            prev_pc   <= pc_in;
            stall_cnt <= same ? stall_cnt + 32'd1 : '0;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    assign term = !pc_valid                           ? 3'd2 :
                  pc_in == HALT_PC                    ? 3'd1 :
                  stall_hit                           ? 3'd4 :
                  cycle_count == 32'(MAX_CYCLES - 1)  ? 3'd3 : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? RUN : state;
            RUN:        next = term != 3'd0 ? DUMP : RUN;
            DUMP:       next = k == 5'd31 ? DONE : DUMP;
            default:    next = state;
        endcase
    end

    assign cpu_rstn = state != IDLE;
    assign cpu_hold = state != RUN;
    assign running  = state == RUN;
    assign done     = state == DONE;
    assign reg_sel  = state == DUMP ? k : 5'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause       <= '0;
            cycle_count <= '0;
            k           <= '0;
            dump_valid  <= 1'b0;
            dump_idx    <= '0;
            dump_data   <= '0;
        end else begin
            dump_valid <= state == DUMP;
            if (launch) begin
                cause       <= '0;
                cycle_count <= '0;
                k           <= '0;
            end
            if (state == RUN) begin
                cycle_count <= cycle_count + 32'(cycle_count != '1);
                if (term != 3'd0) cause <= term;
            end
            if (state == DUMP) begin
                dump_data <= reg_data;
                dump_idx  <= k;
                k         <= k + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed scenarios with scoreboard queues for run results and dump beats.
module tb_run_monitor;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, pc_valid = 1'b1;
    logic [31:0] pc_in = '0;
    logic        cpu_rstn, cpu_hold, running, done, dump_valid;
    logic [4:0]  reg_sel, dump_idx;
    logic [2:0]  cause;
    logic [31:0] cycle_count, dump_data, reg_data;
    logic        t_cpu_rstn, t_cpu_hold, t_running, t_done, t_dump_valid;
    logic [4:0]  t_reg_sel, t_dump_idx;
    logic [2:0]  t_cause;
    logic [31:0] t_cycle_count, t_dump_data, t_reg_data;

    typedef struct packed {logic [2:0] cause; logic [31:0] count;} exp_t;
    exp_t        exp_q[$];
    logic [36:0] beat_q[$];
    int vectors = 0, errors = 0;

    assign reg_data   = 32'hA5000000 | {27'd0, reg_sel};
    assign t_reg_data = 32'hA5000000 | {27'd0, t_reg_sel};

    run_monitor dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .pc_valid(pc_valid),
        .reg_data(reg_data), .cpu_rstn(cpu_rstn), .cpu_hold(cpu_hold), .reg_sel(reg_sel),
        .running(running), .done(done), .cause(cause), .cycle_count(cycle_count),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data)
    );

    run_monitor #(.MAX_CYCLES(10)) dut_t (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .pc_valid(pc_valid),
        .reg_data(t_reg_data), .cpu_rstn(t_cpu_rstn), .cpu_hold(t_cpu_hold), .reg_sel(t_reg_sel),
        .running(t_running), .done(t_done), .cause(t_cause), .cycle_count(t_cycle_count),
        .dump_valid(t_dump_valid), .dump_idx(t_dump_idx), .dump_data(t_dump_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; pc_valid = 1'b1; pc_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: pc=4k, 1: pc=0x1000+k, 2: invalid with pc=HALT_PC at cycle 5, 3: pc stuck at 0x40 from cycle 3
    task automatic run_prog(input int mode, input bit use_t);
        for (int k = 0; k < 1200; k++) begin
            pc_valid = 1'b1;
            case (mode)
                0: pc_in = 32'(4 * k);
                1: pc_in = 32'h1000 + 32'(k);
                2: begin pc_in = k == 5 ? 32'h100 : 32'(4 * k); pc_valid = k != 5; end
                default: pc_in = k < 3 ? 32'(4 * k) : 32'h40;
            endcase
            tick();
            if (!(use_t ? t_running : running)) break;
        end
        pc_valid = 1'b1;
    endtask

    task automatic wait_done(input bit use_t, output int edges);
        edges = 0;
        while (!(use_t ? t_done : done) && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic check_result(input exp_t e, input logic [2:0] c, input logic [31:0] n, input logic d, input string name);
        vectors++;
        if (d !== 1'b1 || c !== e.cause || n !== e.count) begin
            errors++;
            $display("FAIL %s: done=%b cause=%0d cycle_count=%0d, required done=1 cause=%0d cycle_count=%0d",
                     name, d, c, n, e.cause, e.count);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({cpu_rstn, cpu_hold, reg_sel, running, done, cause, cycle_count, dump_valid, dump_idx, dump_data}
            !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset: rstn=%b hold=%b sel=%0d run=%b done=%b cause=%0d cnt=%0d dv=%b idx=%0d data=%h, required 0 1 0 0 0 0 0 0 0 0",
                     cpu_rstn, cpu_hold, reg_sel, running, done, cause, cycle_count, dump_valid, dump_idx, dump_data);
        end
    endtask

    task automatic test_halt();
        int edges;
        apply_reset();
        exp_q.push_back('{cause: 3'd1, count: 32'd65});
        launch();
        vectors++;
        if (running !== 1'b1 || cpu_rstn !== 1'b1 || cpu_hold !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL run_entry: run=%b rstn=%b hold=%b cnt=%0d, required 1 1 0 0", running, cpu_rstn, cpu_hold, cycle_count);
        end
        run_prog(0, 1'b0);
        wait_done(1'b0, edges);
        vectors++;
        if (edges + 1 != 33) begin
            errors++;
            $display("FAIL halt_latency: done %0d edges after halt edge, required 33", edges + 1);
        end
        check_result(exp_q.pop_front(), cause, cycle_count, done, "halt");
        vectors++;
        if (cpu_rstn !== 1'b1 || cpu_hold !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL done_outputs: rstn=%b hold=%b run=%b, required 1 1 0", cpu_rstn, cpu_hold, running);
        end
    endtask

    task automatic test_timeout();
        int edges;
        apply_reset();
        exp_q.push_back('{cause: 3'd3, count: 32'd10});
        launch();
        run_prog(1, 1'b1);
        wait_done(1'b1, edges);
        check_result(exp_q.pop_front(), t_cause, t_cycle_count, t_done, "timeout");
    endtask

    task automatic test_invalid();
        int edges;
        apply_reset();
        exp_q.push_back('{cause: 3'd2, count: 32'd6});
        launch();
        run_prog(2, 1'b0);
        wait_done(1'b0, edges);
        check_result(exp_q.pop_front(), cause, cycle_count, done, "invalid");
    endtask

    task automatic test_stall();
        int edges;
        apply_reset();
`ifdef RUN_MONITOR_STALL_EN
        exp_q.push_back('{cause: 3'd4, count: 32'd20});
`else
        exp_q.push_back('{cause: 3'd3, count: 32'd1000});
`endif
        launch();
        run_prog(3, 1'b0);
        wait_done(1'b0, edges);
        check_result(exp_q.pop_front(), cause, cycle_count, done, "stall");
    endtask

    task automatic test_dump();
        int beats = 0;
        logic [36:0] b;
        apply_reset();
        launch();
        for (int i = 0; i < 32; i++) beat_q.push_back({5'(i), 32'hA5000000 | 32'(i)});
        run_prog(0, 1'b0);
        for (int j = 0; j < 40 && !done; j++) begin
            vectors++;
            if (reg_sel !== 5'(j) || cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL dump_sel: reg_sel=%0d hold=%b, required %0d 1", reg_sel, cpu_hold, j);
            end
            tick();
            if (dump_valid === 1'b1) begin
                b = beat_q.size() > 0 ? beat_q.pop_front() : 37'h1F_FFFF_FFFF;
                beats++;
                vectors++;
                if ({dump_idx, dump_data} !== b) begin
                    errors++;
                    $display("FAIL dump_beat: idx=%0d data=%h, required idx=%0d data=%h", dump_idx, dump_data, b[36:32], b[31:0]);
                end
            end
        end
        vectors++;
        if (beats != 32 || done !== 1'b1) begin
            errors++;
            $display("FAIL dump_count: beats=%0d done=%b, required 32 1", beats, done);
        end
        beat_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dump_valid !== 1'b0 || cause !== 3'd1 || cycle_count !== 32'd65 || dump_data !== 32'hA500001F || done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: dv=%b cause=%0d cnt=%0d data=%h done=%b, required 0 1 65 a500001f 1",
                         dump_valid, cause, cycle_count, dump_data, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        launch();
        vectors++;
        if (running !== 1'b1 || cause !== 3'd0 || cycle_count !== 32'd0 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart: run=%b cause=%0d cnt=%0d dv=%b, required 1 0 0 0", running, cause, cycle_count, dump_valid);
        end
        exp_q.push_back('{cause: 3'd1, count: 32'd65});
        run_prog(0, 1'b0);
        wait_done(1'b0, edges);
        check_result(exp_q.pop_front(), cause, cycle_count, done, "back_to_back");
    endtask

    task automatic test_reset_mid_dump();
        int n = 0, edges;
        apply_reset();
        launch();
        run_prog(0, 1'b0);
        while (!(dump_valid === 1'b1 && dump_idx === 5'd12) && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 40) begin
            errors++;
            $display("FAIL beat12_reached: no beat 12 within 40 cycles, required one");
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({cpu_rstn, cpu_hold, reg_sel, running, done, cause, cycle_count, dump_valid, dump_idx, dump_data}
            !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL mid_dump_reset: rstn=%b hold=%b sel=%0d run=%b done=%b cause=%0d cnt=%0d dv=%b idx=%0d data=%h, required 0 1 0 0 0 0 0 0 0 0",
                     cpu_rstn, cpu_hold, reg_sel, running, done, cause, cycle_count, dump_valid, dump_idx, dump_data);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (running !== 1'b0 || cpu_rstn !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset: run=%b rstn=%b, required 0 0", running, cpu_rstn);
        end
        rst = 1'b0;
        launch();
        vectors++;
        if (running !== 1'b1 || cycle_count !== 32'd0 || cause !== 3'd0) begin
            errors++;
            $display("FAIL clean_restart: run=%b cnt=%0d cause=%0d, required 1 0 0", running, cycle_count, cause);
        end
        exp_q.push_back('{cause: 3'd1, count: 32'd65});
        run_prog(0, 1'b0);
        wait_done(1'b0, edges);
        check_result(exp_q.pop_front(), cause, cycle_count, done, "after_reset");
    endtask

    initial begin
        test_reset();
        test_halt();
        test_timeout();
        test_invalid();
        test_stall();
        test_dump();
        test_back_to_back();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
